// File: rtl/fib_sequencer.sv
// ---------------------------------------------------------------------------
// fib_sequencer
//
// Purpose:
//   Multi-cycle controller that drives a shared combinational ALU to compute
//   the n-th term of a Fibonacci-style sequence F(k) = F(k-1) + F(k-2),
//   starting from the seeds F(0)=f0 and F(1)=f1. One ADD is issued per clock.
//   The ALU result is captured back into the internal a/b term registers.
//   A start/done handshake connects it to the board I/O.
//
// Build option:
//   FIB_OVF_DETECT_EN - when defined, an unsigned wrap of an ADD ends the run
//                       early. result then holds the last term that fit, and
//                       ovf is raised. When undefined, sums wrap modulo 2^W
//                       and ovf_o is tied low. The port list is the same in
//                       both builds.
//
// Ports:
//   clk_i      in   1     clock, rising edge
//   rst_i      in   1     asynchronous, active-high reset
//   start_i    in   1     request, sampled only in IDLE
//   f0_i       in   W     seed F(0), latched on an accepted start
//   f1_i       in   W     seed F(1), latched on an accepted start
//   n_i        in   CW    index of the requested term, latched on an accepted start
//   alu_op_o   out  OPW   ALU opcode (always OP_ADD)
//   alu_a_o    out  W     ALU operand A (a in RUN, otherwise 0)
//   alu_b_o    out  W     ALU operand B (b in RUN, otherwise 0)
//   alu_c_i    in   W     ALU result, combinational from alu_a/alu_b/alu_op
//   busy_o     out  1     high in RUN and FIN
//   done_o     out  1     one-cycle pulse, result_o valid
//   result_o   out  W     F(n), held until the next accepted start
//   ovf_o      out  1     overflow flag, valid with done_o
//
// States:
//   state  | meaning
//   IDLE   | waiting for start_i; the ALU operands are parked at 0
//   RUN    | one ADD per cycle, with a <= b and b <= a + b
//   FIN    | result is valid and done is high for exactly one cycle
// ---------------------------------------------------------------------------
module fib_sequencer #(
  parameter int                W      = 8,
  parameter int                CW     = 8,
  parameter int                OPW    = 3,
  parameter logic [OPW-1:0]    OP_ADD = OPW'(4)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [W-1:0]   f0_i,
  input  logic [W-1:0]   f1_i,
  input  logic [CW-1:0]  n_i,
  output logic [OPW-1:0] alu_op_o,
  output logic [W-1:0]   alu_a_o,
  output logic [W-1:0]   alu_b_o,
  input  logic [W-1:0]   alu_c_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [W-1:0]   result_o,
  output logic           ovf_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e        state_q,  state_d;
  logic [W-1:0]  a_q,      a_d;
  logic [W-1:0]  b_q,      b_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [CW-1:0] n_q,      n_d;
  logic [W-1:0]  result_q, result_d;
  logic          busy_q,   busy_d;
  logic          done_q,   done_d;
  logic [W-1:0]  alu_a_q,  alu_a_d;
  logic [W-1:0]  alu_b_q,  alu_b_d;
`ifdef FIB_OVF_DETECT_EN
  logic          ovf_q,    ovf_d;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    result_d = result_q;
`ifdef FIB_OVF_DETECT_EN
    ovf_d    = ovf_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_d   = f0_i;
          b_d   = f1_i;
          cnt_d = CW'(1);
          n_d   = n_i;
`ifdef FIB_OVF_DETECT_EN
          ovf_d = 1'b0;
`endif
          // F(0) and F(1) are the seeds themselves, so no ADD is needed.
          if (n_i < CW'(2)) begin
            result_d = (n_i == '0) ? f0_i : f1_i;
            state_d  = S_FIN;
          end else begin
            state_d  = S_RUN;
          end
        end
      end

      S_RUN: begin
        a_d   = b_q;
        b_d   = alu_c_i;
        cnt_d = cnt_q + CW'(1);
`ifdef FIB_OVF_DETECT_EN
        // For unsigned operands, a sum that wrapped is always smaller than
        // either addend. In that case b is the last term that still fit.
        if (alu_c_i < b_q) begin
          result_d = b_q;
          ovf_d    = 1'b1;
          state_d  = S_FIN;
        end else
`endif
        // cnt counts the term held in b. The ADD in this cycle therefore
        // produces term cnt+1, and that is F(n) when cnt == n-1. Since n <= 2^CW-1,
        // cnt stops at 2^CW-2 and never wraps.
        if (cnt_q == n_q - CW'(1)) begin
          result_d = alu_c_i;
          state_d  = S_FIN;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The outputs are registered from next-state values, so they stay Moore
    // with respect to state_q without an output decode after the flops.
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_FIN);
    alu_a_d = (state_d == S_RUN) ? a_d : '0;
    alu_b_d = (state_d == S_RUN) ? b_d : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      n_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
`ifdef FIB_OVF_DETECT_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
`ifdef FIB_OVF_DETECT_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign alu_op_o = OP_ADD;
  assign alu_a_o  = alu_a_q;
  assign alu_b_o  = alu_b_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
`ifdef FIB_OVF_DETECT_EN
  assign ovf_o    = ovf_q;
`else
  assign ovf_o    = 1'b0;
`endif

endmodule

// File: tb/tb_fib_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fib_sequencer
//
// Self-checking bench for fib_sequencer. It includes a small adder that
// stands in for the ALU. Each request pushes its expected result, ovf flag
// and edge count onto a queue. The entry is popped when done is seen. On
// every RUN cycle the bench also compares the ALU operands with a model of
// a and b.
// ---------------------------------------------------------------------------
module tb_fib_sequencer;

`ifdef FIB_OVF_DETECT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [7:0] f0_i, f1_i, n_i;
  logic [2:0] alu_op_o;
  logic [7:0] alu_a_o, alu_b_o, alu_c_i;
  logic       busy_o, done_o, ovf_o;
  logic [7:0] result_o;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [7:0] res;
    logic       ovf;
    int         edges;
  } exp_t;

  exp_t exp_q[$];

  fib_sequencer dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .f0_i    (f0_i),
    .f1_i    (f1_i),
    .n_i     (n_i),
    .alu_op_o(alu_op_o),
    .alu_a_o (alu_a_o),
    .alu_b_o (alu_b_o),
    .alu_c_i (alu_c_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .result_o(result_o),
    .ovf_o   (ovf_o)
  );

  // The ALU only adds when it sees the ADD opcode (4).
  assign alu_c_i = (alu_op_o == 3'd4) ? alu_a_o + alu_b_o : 8'h00;

  always #5 clk_i = ~clk_i;

  function automatic exp_t model(input logic [7:0] f0, input logic [7:0] f1,
                                 input logic [7:0] n);
    exp_t e;
    logic [7:0] a, b, c;
    e.ovf   = 1'b0;
    e.edges = 1;
    e.res   = 8'h00;
    if (n == 8'd0) e.res = f0;
    else if (n == 8'd1) e.res = f1;
    else begin
      a = f0;
      b = f1;
      for (int k = 2; k <= int'(n); k++) begin
        c = a + b;
        e.edges++;
        if (OVF_EN && (c < b)) begin
          e.res = b;
          e.ovf = 1'b1;
          break;
        end
        a = b;
        b = c;
        e.res = c;
      end
    end
    return e;
  endfunction

  // Called at a negedge in IDLE. Returns at the negedge of the IDLE cycle
  // that follows done.
  task automatic run_req(input logic [7:0] f0, input logic [7:0] f1,
                         input logic [7:0] n, input bit hold, input bit disturb);
    logic [7:0] ma, mb;
    int   edges;
    bit   finished;
    exp_t e;
    f0_i = f0; f1_i = f1; n_i = n; start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i  = hold;
    edges    = 1;
    finished = 1'b0;
    ma = f0;
    mb = f1;
    for (int guard = 0; guard < 300; guard++) begin
      @(negedge clk_i);
      if (done_o) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_done: done seen with empty scoreboard");
        end else begin
          e = exp_q.pop_front();
          if (result_o !== e.res) begin
            tests_failed++;
            $display("FAIL result n=%0d: got %0d want %0d", n, result_o, e.res);
          end
          tests_run++;
          if (ovf_o !== e.ovf) begin
            tests_failed++;
            $display("FAIL ovf n=%0d: got %b want %b", n, ovf_o, e.ovf);
          end
          tests_run++;
          if (edges != e.edges) begin
            tests_failed++;
            $display("FAIL latency n=%0d: got %0d edges want %0d", n, edges, e.edges);
          end
        end
        tests_run++;
        if (busy_o !== 1'b1 || alu_a_o !== 8'h00 || alu_b_o !== 8'h00) begin
          tests_failed++;
          $display("FAIL fin_outputs: busy=%b a=%0d b=%0d want 1/0/0", busy_o, alu_a_o, alu_b_o);
        end
        f0_i = f0; f1_i = f1; n_i = n; start_i = hold;
        finished = 1'b1;
        break;
      end
      tests_run++;
      if (busy_o !== 1'b1 || alu_op_o !== 3'd4 || alu_a_o !== ma || alu_b_o !== mb) begin
        tests_failed++;
        $display("FAIL run_cycle edge=%0d: busy=%b op=%0d a=%0d b=%0d want 1/4/%0d/%0d",
                 edges, busy_o, alu_op_o, alu_a_o, alu_b_o, ma, mb);
      end
      mb = ma + mb;
      ma = alu_b_o;
      if (disturb) begin
        f0_i = 8'($urandom); f1_i = 8'($urandom); n_i = 8'($urandom);
        start_i = hold ? 1'b1 : 1'(($urandom));
      end
      @(posedge clk_i);
      edges++;
    end
    if (!finished) begin
      tests_run++;
      tests_failed++;
      $display("FAIL timeout n=%0d: no done within 300 cycles", n);
      start_i = 1'b0;
    end
    @(negedge clk_i);
    tests_run++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_done: done=%b busy=%b want 0/0", done_o, busy_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; f0_i = 8'h00; f1_i = 8'h00; n_i = 8'h00;
    @(negedge clk_i);
    @(negedge clk_i);
    tests_run++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 8'h00 || ovf_o !== 1'b0 ||
        alu_a_o !== 8'h00 || alu_b_o !== 8'h00 || alu_op_o !== 3'd4) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%b done=%b res=%0d ovf=%b a=%0d b=%0d op=%0d",
               busy_o, done_o, result_o, ovf_o, alu_a_o, alu_b_o, alu_op_o);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_basic();
    exp_t e;
    e.res = 8'd55; e.ovf = 1'b0; e.edges = 10;
    exp_q.push_back(e);
    run_req(8'd0, 8'd1, 8'd10, 1'b0, 1'b0);
    exp_q.push_back(model(8'd7, 8'd3, 8'd2));
    run_req(8'd7, 8'd3, 8'd2, 1'b0, 1'b0);
  endtask

  task automatic test_short();
    exp_t e;
    e.res = 8'h5A; e.ovf = 1'b0; e.edges = 1;
    exp_q.push_back(e);
    run_req(8'h5A, 8'hA5, 8'd0, 1'b0, 1'b0);
    e.res = 8'hA5;
    exp_q.push_back(e);
    run_req(8'h5A, 8'hA5, 8'd1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    e.res = 8'd5; e.ovf = 1'b0; e.edges = 5;
    exp_q.push_back(e);
    run_req(8'd0, 8'd1, 8'd5, 1'b1, 1'b1);
    exp_q.push_back(e);
    run_req(8'd0, 8'd1, 8'd5, 1'b1, 1'b0);
    start_i = 1'b0;
    @(negedge clk_i);
    exp_q.push_back(model(8'd3, 8'd4, 8'd8));
    run_req(8'd3, 8'd4, 8'd8, 1'b0, 1'b1);
  endtask

  task automatic test_overflow();
    exp_t e;
    e.edges = 14;
    e.res = OVF_EN ? 8'd233 : 8'd121;
    e.ovf = OVF_EN;
    exp_q.push_back(e);
    run_req(8'd0, 8'd1, 8'd14, 1'b0, 1'b0);
    exp_q.push_back(model(8'd0, 8'd1, 8'd20));
    run_req(8'd0, 8'd1, 8'd20, 1'b0, 1'b0);
    exp_q.push_back(model(8'd0, 8'd0, 8'd255));
    run_req(8'd0, 8'd0, 8'd255, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    f0_i = 8'd0; f1_i = 8'd1; n_i = 8'd20; start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    for (int i = 1; i <= 6; i++) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    tests_run++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== 8'h00 || ovf_o !== 1'b0 ||
        alu_a_o !== 8'h00 || alu_b_o !== 8'h00) begin
      tests_failed++;
      $display("FAIL async_abort: busy=%b done=%b res=%0d ovf=%b a=%0d b=%0d want all 0",
               busy_o, done_o, result_o, ovf_o, alu_a_o, alu_b_o);
    end
    @(negedge clk_i);
    tests_run++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_no_done: done=%b busy=%b want 0/0", done_o, busy_o);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    e.res = 8'd2; e.ovf = 1'b0; e.edges = 3;
    exp_q.push_back(e);
    run_req(8'd0, 8'd1, 8'd3, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] f0, f1, n;
    for (int r = 0; r < 6; r++) begin
      f0 = 8'($urandom);
      f1 = 8'($urandom);
      n  = 8'($urandom_range(0, 40));
      exp_q.push_back(model(f0, f1, n));
      run_req(f0, f1, n, 1'b0, r[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short();
    test_back_to_back();
    test_overflow();
    test_reset_mid_run();
    test_random();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
